// File: rtl/hazard_ctrl.sv
// Hazard, stall and flush sequencer for the 5-stage RV32I pipeline.
// Load-use bubbles, EX-resolved redirects, memory freeze with deferred redirect, perf counters.
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode_IFID,
  input  logic [4:0]       rs1_IFID,
  input  logic [4:0]       rs2_IFID,
  input  logic [4:0]       rd_IDEX,
  input  logic             memRead_IDEX,
  input  logic             branch_taken_EX,
  input  logic [31:0]      branch_target_EX,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_hold,
  output logic             control_mux_sel,
  output logic             flush_IF,
  output logic             flush_ID,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_e;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [31:0]       tgt_q, tgt_d;
  logic [15:0]       wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              timeout_q, timeout_d;
  logic              uses_rs1, uses_rs2, lu;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode_IFID)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign lu = memRead_IDEX && (rd_IDEX != 5'd0) &&
              ((uses_rs1 && (rd_IDEX == rs1_IFID)) || (uses_rs2 && (rd_IDEX == rs2_IFID)));

  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    tgt_d           = tgt_q;
    wait_d          = wait_q;
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    idex_hold       = 1'b0;
    control_mux_sel = 1'b0;
    flush_IF        = 1'b0;
    flush_ID        = 1'b0;
    pc_redirect     = 1'b0;
    redirect_pc     = (state_q == REDIRECT) ? tgt_q : branch_target_EX;

    // wait_cnt counts the busy cycles of the current freeze, including the entering one
    if (dmem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
      state_d    = MEM_WAIT;
      if (state_q == MEM_WAIT) begin
        wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
      end else begin
        wait_d = 16'd1;
      end
      if (branch_taken_EX && (state_q != REDIRECT)) begin
        pending_d = 1'b1;
        tgt_d     = branch_target_EX;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken_EX) begin
            flush_IF    = 1'b1;
            flush_ID    = 1'b1;
            pc_redirect = 1'b1;
          end else if (lu) begin
            pc_write        = 1'b0;
            ifid_write      = 1'b0;
            control_mux_sel = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (pending_q) begin
            state_d = REDIRECT;
          end else begin
            state_d = RUN;
            if (lu) begin
              pc_write        = 1'b0;
              ifid_write      = 1'b0;
              control_mux_sel = 1'b1;
            end
          end
        end
        REDIRECT: begin
          flush_IF    = 1'b1;
          flush_ID    = 1'b1;
          pc_redirect = 1'b1;
          pending_d   = 1'b0;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end

    timeout_d = timeout_q | (wait_d >= TIMEOUT_C);
    stall_d   = (!pc_write && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    flush_d   = (pc_redirect && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;

    // Reset drives a safe frozen-and-flushed pipeline regardless of state
    if (!rst_n) begin
      pc_write        = 1'b0;
      ifid_write      = 1'b0;
      idex_hold       = 1'b0;
      control_mux_sel = 1'b1;
      flush_IF        = 1'b1;
      flush_ID        = 1'b1;
      pc_redirect     = 1'b0;
      redirect_pc     = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
      tgt_q     <= 32'd0;
      wait_q    <= 16'd0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      tgt_q     <= tgt_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
  assign mem_timeout = timeout_q;

endmodule
